// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, constants and FSM encoding for the fetch stage
package inst_fetch_pkg;
    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 64;

    localparam logic                   CHIP_ENABLE      = 1'b1;
    localparam logic                   CHIP_DISABLE     = 1'b0;
    localparam logic [INST_W-1:0]      ZERO_DOUBLE_WORD = '0;
    localparam logic [INST_ADDR_W-1:0] FETCH_STRIDE     = 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    // Instructions are 64-bit, so every legal fetch address is a multiple of 8.
    function automatic logic is_aligned(input logic [INST_ADDR_W-1:0] addr);
        return addr[2:0] == 3'b000;
    endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - ROM port and IF/ID outputs of the fetch stage
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic                   rom_ce;
    logic [INST_ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0]      rom_inst;
    logic [INST_ADDR_W-1:0] id_pc;
    logic [INST_W-1:0]      id_inst;
    logic                   id_valid;

    modport master (
        output rom_ce, rom_addr, id_pc, id_inst, id_valid,
        input  rom_inst
    );

    modport slave (
        input  rom_ce, rom_addr, id_pc, id_inst, id_valid,
        output rom_inst
    );
endinterface

// File: rtl/inst_fetch_if_id.sv
// rtl/inst_fetch_if_id.sv - IF/ID pipeline register with bubble/hold/load controls
module if_id
    import inst_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   bubble,
    input  logic                   hold,
    input  logic [INST_ADDR_W-1:0] pc,
    input  logic [INST_W-1:0]      inst,
    output logic [INST_ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0]      id_inst,
    output logic                   id_valid
);
    // Bubble beats hold beats load, so a redirect always clears the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc    <= '0;
            id_inst  <= ZERO_DOUBLE_WORD;
            id_valid <= 1'b0;
        end else if (bubble) begin
            id_pc    <= '0;
            id_inst  <= ZERO_DOUBLE_WORD;
            id_valid <= 1'b0;
        end else if (!hold && load) begin
            id_pc    <= pc;
            id_inst  <= inst;
            id_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC, fetch FSM and delivered-instruction counter feeding if_id
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   branch_flag,
    input  logic [INST_ADDR_W-1:0] branch_target_addr,
    inst_fetch_if.master           bus,
    output logic                   fetch_fault,
    output logic [31:0]            fetch_count
);
    fetch_state_t           state;
    logic [INST_ADDR_W-1:0] pc;
    logic                   active;
    logic                   take_branch;
    logic                   redirect;
    logic                   load;
    logic                   hold;
    logic [INST_ADDR_W-1:0] target;

    // Flush wins over stall and branch; a branch seen during stall is dropped.
    assign active      = (state != ST_IDLE);
    assign take_branch = (state == ST_FETCH) && !stall && branch_flag && !flush;
    assign redirect    = (active && flush) || take_branch;
    assign target      = flush ? new_pc : branch_target_addr;
    assign load        = (state == ST_FETCH) && !flush && !stall && !branch_flag;
    assign hold        = !redirect && !load;

    assign bus.rom_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pc          <= '0;
            bus.rom_ce  <= CHIP_DISABLE;
            fetch_fault <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state      <= ST_FETCH;
                    bus.rom_ce <= CHIP_ENABLE;
                end
                default: begin
                    if (redirect) begin
                        pc <= target;
                        if (is_aligned(target)) begin
                            state       <= ST_FETCH;
                            bus.rom_ce  <= CHIP_ENABLE;
                            fetch_fault <= 1'b0;
                        end else begin
                            state       <= ST_FAULT;
                            bus.rom_ce  <= CHIP_DISABLE;
                            fetch_fault <= 1'b1;
                        end
                    end else if (load) begin
                        pc <= pc + FETCH_STRIDE;
                        if (fetch_count != 32'hFFFF_FFFF)
                            fetch_count <= fetch_count + 32'd1;
                    end
                end
            endcase
        end
    end

    if_id u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .bubble   (redirect),
        .hold     (hold),
        .pc       (pc),
        .inst     (bus.rom_inst),
        .id_pc    (bus.id_pc),
        .id_inst  (bus.id_inst),
        .id_valid (bus.id_valid)
    );
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state SHALL update on its rising edge.
REQ-002 The port rst SHALL be an input, 1 bit wide, and SHALL be an asynchronous, active-low reset.
REQ-003 The port stall SHALL be an input, 1 bit wide; when high it SHALL hold the PC and the IF/ID register.
REQ-004 The port flush SHALL be an input, 1 bit wide, and SHALL signal an exception redirect to new_pc.
REQ-005 The port new_pc SHALL be an input, `InstAddrBus wide (32 bits), and SHALL carry the flush target.
REQ-006 The port branch_flag SHALL be an input, 1 bit wide, and SHALL signal a taken branch from ID.
REQ-007 The port branch_target_addr SHALL be an input, `InstAddrBus wide, and SHALL carry the branch target.
REQ-008 The port rom_ce SHALL be an output, 1 bit wide, and SHALL be the chip enable to the instruction ROM.
REQ-009 The port rom_addr SHALL be an output, `InstAddrBus wide, and SHALL be the byte address to the ROM, equal to pc.
REQ-010 The port rom_inst SHALL be an input, `InstBus wide (64 bits), and SHALL be the combinational ROM data for rom_addr.
REQ-011 The port id_pc SHALL be an output, `InstAddrBus wide, and SHALL be the IF/ID PC.
REQ-012 The port id_inst SHALL be an output, `InstBus wide, and SHALL be the IF/ID instruction.
REQ-013 The port id_valid SHALL be an output, 1 bit wide, and SHALL be high when the IF/ID register holds a real instruction.
REQ-014 The port fetch_fault SHALL be an output, 1 bit wide, and SHALL be high while the block is in FAULT.
REQ-015 The port fetch_count SHALL be an output, 32 bits wide, and SHALL count instructions delivered to ID.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, FETCH and FAULT.
REQ-017 In IDLE, rom_ce SHALL be `ChipDisable, and the FSM SHALL move to FETCH unconditionally on the first clock edge after rst deasserts.
REQ-018 In FETCH, rom_ce SHALL be `ChipEnable; in FAULT and IDLE, rom_ce SHALL be `ChipDisable.
REQ-019 Each FETCH cycle with no stall, flush or branch SHALL load id_pc<=pc, id_inst<=rom_inst, id_valid<=1, pc<=pc+8, fetch_count+=1.
REQ-020 PC arithmetic SHALL be 32-bit modulo: 0xFFFFFFF8+8 SHALL wrap to 0x00000000 with no fault.
REQ-021 When stall is high without flush, pc, id_pc, id_inst, id_valid and fetch_count SHALL all hold.
REQ-022 When branch_flag is high without stall or flush, the block SHALL set pc<=branch_target_addr and load IF/ID with a bubble (id_valid=0, id_inst=`ZeroDoubleWord, id_pc=0); there SHALL be no delay slot.
REQ-023 When flush is high, it SHALL override stall and branch_flag: pc<=new_pc, IF/ID bubble, FSM<=FETCH from any state except IDLE.
REQ-024 A redirect target (branch or flush) with bits [2:0] not equal to 0 SHALL set FSM<=FAULT, load an IF/ID bubble and keep pc at the offending target.
REQ-025 In FAULT, fetch_fault SHALL be 1 and id_valid SHALL be 0; the block SHALL leave FAULT only via an aligned flush.
REQ-026 When stall is high in the same cycle as branch_flag, the branch SHALL be ignored; ID reasserts it once unstalled.
REQ-027 fetch_count SHALL saturate at 0xFFFFFFFF.
REQ-028 In the IDLE-to-FETCH cycle, no instruction SHALL be latched; the first id_valid SHALL be 1 one cycle after FETCH is entered.

Reset
REQ-029 When rst is low, the block SHALL asynchronously force state=IDLE, pc=0, rom_ce=`ChipDisable, id_pc=0, id_inst=`ZeroDoubleWord, id_valid=0, fetch_fault=0 and fetch_count=0.
REQ-030 A reset asserted mid-stall, mid-branch or in FAULT SHALL discard all pending state; no redirect SHALL survive reset.

Structure
REQ-031 State encodings and the fetch stride constant (8) SHALL be placed in defines.v alongside `InstAddrBus, `InstBus, `ChipEnable, `ChipDisable and `ZeroDoubleWord.
REQ-032 The IF/ID register SHALL be the single sub-module if_id, with inputs for load, bubble and hold; the PC, FSM and counter SHALL remain in inst_fetch.

Verification
REQ-033 The bench SHALL check reset release: rom_ce=0 for one cycle, then the ROM is fetched at addresses 0, 8 and 0x10, with id_pc=0, 8 and 0x10 in consecutive cycles and fetch_count=3.
REQ-034 The bench SHALL check stall held for 3 cycles at pc=0x18: id_pc stays at 0x10 and pc stays at 0x18; after release, id_pc=0x18.
REQ-035 The bench SHALL check branch_flag=1 with target 0x100: next cycle id_valid=0 and rom_addr=0x100; the following cycle id_pc=0x100.
REQ-036 The bench SHALL check flush=1 with new_pc=0x40 while stall=1 and branch_flag=1 with target 0x200: the result is pc=0x40, an IF/ID bubble, and the branch is dropped.
REQ-037 The bench SHALL check branch_flag with target 0x104: fetch_fault=1, rom_ce=0 and id_valid=0 persist; then flush with new_pc=0x80 returns the block to FETCH with id_pc=0x80 one cycle later.
REQ-038 The bench SHALL check rst asserted asynchronously mid-cycle while in FAULT: all outputs immediately reach reset values, and restart fetches from 0.
